// File: rtl/counting.sv
// MM:SS stopwatch counter with an enable-qualified prescaler on the timer clock.
// Optional feature macro: COUNTING_ROLLOVER_EN (defined: wrap MAX_MIN:59 -> 00:00;
// undefined: saturate at MAX_MIN:59 until reset).
module counting #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned MAX_MIN       = 59
) (
    input  logic       timer,
    input  logic       reset,
    input  logic       enable,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);

    localparam int unsigned PRESC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned TIME_W   = 6;
    localparam int unsigned LAST_SEC = 59;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TIME_W-1:0]  sec_q, sec_d;
    logic [TIME_W-1:0]  min_q, min_d;
    logic               tick_c;

    // Prescaler advance and one-second tick generation; progress holds while paused.
    always_comb begin
        tick_c  = 1'b0;
        presc_d = presc_q;
        if (enable) begin
            if (presc_q == PRESC_W'(TICKS_PER_SEC - 1)) begin
                presc_d = '0;
                tick_c  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Seconds/minutes update on tick, with end-of-range wrap or saturation.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        if (tick_c) begin
            if (sec_q != TIME_W'(LAST_SEC)) begin
                sec_d = sec_q + 1'b1;
            end else if (min_q != TIME_W'(MAX_MIN)) begin
                sec_d = '0;
                min_d = min_q + 1'b1;
            end else begin
`ifdef COUNTING_ROLLOVER_EN
                sec_d = '0;
                min_d = '0;
`else
                sec_d = sec_q;
                min_d = min_q;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset that overrides enable.
    always_ff @(posedge timer) begin
        if (!reset) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;

endmodule

// File: tb/tb_counting.sv
// Randomized self-checking bench for counting; expected time is derived from the
// number of enabled edges since the last reset.
module tb_counting;

    logic       timer  = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] m1, s1, m4, s4, ms, ss;

    int n      = 0;
    int checks = 0;
    int errors = 0;

    always #5 timer = ~timer;

    counting #(.TICKS_PER_SEC(1), .MAX_MIN(59)) u_d1 (
        .timer(timer), .reset(reset), .enable(enable), .minutes(m1), .seconds(s1));
    counting #(.TICKS_PER_SEC(4), .MAX_MIN(59)) u_d4 (
        .timer(timer), .reset(reset), .enable(enable), .minutes(m4), .seconds(s4));
    counting #(.TICKS_PER_SEC(3), .MAX_MIN(2)) u_ds (
        .timer(timer), .reset(reset), .enable(enable), .minutes(ms), .seconds(ss));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Elapsed seconds shown after n enabled edges, for a given prescale and minute limit.
    function automatic int exp_total(input int tps, input int mm, input int edges);
        int t;
        int lim;
        t   = edges / tps;
        lim = mm * 60 + 59;
`ifdef COUNTING_ROLLOVER_EN
        t = t % (lim + 1);
`else
        if (t > lim) t = lim;
`endif
        return t;
    endfunction

    task automatic check_dut(input string tag, input logic [5:0] m, input logic [5:0] s,
                             input int tps, input int mm);
        int t;
        t = exp_total(tps, mm, n);
        check({tag, "_min"}, int'(m), t / 60);
        check({tag, "_sec"}, int'(s), t % 60);
    endtask

    task automatic step(input logic r, input logic e);
        reset  = r;
        enable = e;
        @(posedge timer);
        #1;
        if (!r) n = 0;
        else if (e) n++;
        check_dut("d1", m1, s1, 1, 59);
        check_dut("d4", m4, s4, 4, 59);
        check_dut("ds", ms, ss, 3, 2);
    endtask

    initial begin
        // Reset held with enable high
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
        check("rst_hold_min", int'(m1), 0);
        check("rst_hold_sec", int'(s1), 0);

        // 61 enabled edges -> 1:01
        for (int i = 0; i < 61; i++) step(1'b1, 1'b1);
        check("run61_min", int'(m1), 1);
        check("run61_sec", int'(s1), 1);

        // Pause at 0:30, resume for 5 -> 0:35
        step(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        check("pause_sec", int'(s1), 30);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check("resume_min", int'(m1), 0);
        check("resume_sec", int'(s1), 35);

        // Prescale 4: 9 edges -> 2 s, three more reveal residual presc=1
        step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
        check("p4_sec9", int'(s4), 2);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        check("p4_sec11", int'(s4), 2);
        step(1'b1, 1'b1);
        check("p4_sec12", int'(s4), 3);

        // Run to 59:59 then one more tick and 10 extra edges
        step(1'b0, 1'b1);
        for (int i = 0; i < 3599; i++) step(1'b1, 1'b1);
        check("end_min", int'(m1), 59);
        check("end_sec", int'(s1), 59);
        step(1'b1, 1'b1);
`ifdef COUNTING_ROLLOVER_EN
        check("wrap_min", int'(m1), 0);
        check("wrap_sec", int'(s1), 0);
`else
        check("sat_min", int'(m1), 59);
        check("sat_sec", int'(s1), 59);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        check("sat10_min", int'(m1), 59);
        check("sat10_sec", int'(s1), 59);
`endif

        // Mid-count reset at 12:34
        step(1'b0, 1'b1);
        for (int i = 0; i < 754; i++) step(1'b1, 1'b1);
        check("pre_rst_min", int'(m1), 12);
        check("pre_rst_sec", int'(s1), 34);
        step(1'b0, 1'b1);
        check("mid_rst_min", int'(m1), 0);
        check("mid_rst_sec", int'(s1), 0);
        step(1'b1, 1'b1);
        check("post_rst_sec", int'(s1), 1);

        // Random enable / occasional reset
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
